// File: rtl/mem_arbiter.sv
// Shares one word-wide, byte-addressed memory between an I-fill and a D requester.
// Burst reads with fixed wait states and single-word writes. ARB_RR_EN selects round-robin ties.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LAT        = 4,
    parameter int unsigned BURST      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  i_grant,
    output logic                  d_grant,
    output logic                  rd_valid,
    output logic [15:0]           rd_data,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_dst,
    output logic                  done,
    output logic                  busy,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out
);

    localparam int unsigned CntW  = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int unsigned BeatW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [CntW-1:0]       CntInit  = CntW'(LAT - 1);
    localparam logic [BeatW-1:0]      BeatLast = BeatW'(BURST - 1);
    localparam logic [ADDR_WIDTH-1:0] RdMask   = ~ADDR_WIDTH'(2 * BURST - 1);
    localparam logic [ADDR_WIDTH-1:0] WrMask   = ~ADDR_WIDTH'(1);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  wr_q, wr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [BeatW-1:0]      beat_q, beat_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic                  d_wins;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] beat_addr;

`ifdef ARB_RR_EN
    // Side granted most recently: 0 = I, 1 = D. Resets to I so D wins the first tie.
    logic last_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else if (i_grant || d_grant) begin
            last_d_q <= d_grant;
        end
    end

    assign d_wins = d_req & (~i_req | ~last_d_q);
`else
    assign d_wins = d_req;
`endif

    assign beat_addr = base_q + ADDR_WIDTH'({beat_q, 1'b0});

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        base_d      = base_q;
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        sel_addr    = '0;
        i_grant     = 1'b0;
        d_grant     = 1'b0;
        rd_valid    = 1'b0;
        rd_data     = '0;
        rd_addr     = '0;
        rd_dst      = 1'b0;
        done        = 1'b0;
        busy        = 1'b0;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;

        // Everything visible is gated by rst so an aborted transfer never writes or completes.
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (i_req || d_req) begin
                        d_grant  = d_wins;
                        i_grant  = ~d_wins;
                        owner_d  = d_wins;
                        wr_d     = d_wins & d_wr;
                        wdata_d  = d_wdata;
                        sel_addr = d_wins ? d_addr : i_addr;
                        base_d   = (d_wins && d_wr) ? (sel_addr & WrMask) : (sel_addr & RdMask);
                        beat_d   = '0;
                        cnt_d    = CntInit;
                        state_d  = StAccess;
                    end
                end
                StAccess: begin
                    busy        = 1'b1;
                    mem_enable  = 1'b1;
                    mem_addr    = {beat_addr[ADDR_WIDTH-1:1], 1'b0};
                    mem_data_in = wdata_q;
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        if (wr_q) begin
                            mem_wr  = 1'b1;
                            done    = 1'b1;
                            cnt_d   = '0;
                            state_d = StIdle;
                        end else begin
                            rd_valid = 1'b1;
                            rd_data  = mem_data_out;
                            rd_addr  = {beat_addr[ADDR_WIDTH-1:1], 1'b0};
                            rd_dst   = owner_q;
                            if (beat_q == BeatLast) begin
                                done    = 1'b1;
                                cnt_d   = '0;
                                beat_d  = '0;
                                state_d = StIdle;
                            end else begin
                                beat_d = beat_q + 1'b1;
                                cnt_d  = CntInit;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            base_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Multi-cycle controller that shares one single-ported, word-wide (16-bit), byte-addressed memory between an instruction-fill requester (I) and a data requester (D). It inserts a fixed wait-state latency per word to model slow main memory. Reads are serviced as aligned block bursts for cache fills; writes are serviced as single words (write-through). The block sits between the I/D caches and the memory instance, and is the only driver of the memory's enable, write, address and data-in pins.

## Interface
- ADDR_WIDTH, 16, byte address width.
- LAT, 4, cycles per word access; must be ≥1.
- BURST, 8, words per read burst; must be a power of two.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  I-side read request; held until i_grant
- i_addr  in  ADDR_WIDTH  I-side byte address
- d_req  in  1  D-side request; held until d_grant
- d_wr  in  1  D-side: 1 = single-word write, 0 = burst read
- d_addr  in  ADDR_WIDTH  D-side byte address
- d_wdata  in  16  D-side write data
- i_grant, d_grant  out  1  one-cycle acceptance pulse
- rd_valid  out  1  read beat valid
- rd_data  out  16  read beat data
- rd_addr  out  ADDR_WIDTH  byte address of the current beat
- rd_dst  out  1  beat owner: 0 = I, 1 = D
- done  out  1  pulse on the last read beat, or on write completion
- busy  out  1  high in every non-IDLE state
- mem_enable, mem_wr  out  1  memory control
- mem_addr  out  ADDR_WIDTH  memory byte address; bit 0 always 0
- mem_data_in  out  16  memory write data
- mem_data_out  in  16  memory combinational read data

## Operation
- States:
  - IDLE: arbitration.
  - ACCESS: a word is in flight.
- IDLE:
  - If either request is present, pulse the winner's grant.
  - Latch owner, wr, wdata and base address.
    - Read base = addr & ~(2·BURST−1).
    - Write base = addr & ~1.
  - Set beat = 0 and cnt = LAT−1, then go to ACCESS.
- ACCESS:
  - mem_enable = 1.
  - mem_addr = base + 2·beat.
  - mem_wr = 0, except for a write when cnt == 0.
  - mem_data_in = latched wdata.
  - cnt decrements every cycle.
- Read, cnt == 0:
  - rd_valid = 1; rd_data = mem_data_out; rd_addr = mem_addr; rd_dst = owner.
  - If beat == BURST−1: pulse done, go to IDLE.
  - Otherwise: beat++, cnt = LAT−1.
- Write, cnt == 0:
  - mem_wr = 1, so the write occurs on that edge.
  - Pulse done, go to IDLE.
- Beats never wrap; addresses run from base to base + 2·(BURST−1).
- The I side is read-only. A request asserted while busy is ignored until IDLE. Requester inputs are not sampled after the grant.
- mem_enable, mem_wr, rd_valid, done and grants are combinational from state and gated by ~rst.
- Reset values:
  - All outputs are 0, including rd_data and mem_addr.
  - State = IDLE; cnt = 0; beat = 0.
- Reset mid-transaction: abort with no done pulse and no memory write. The next grant is possible in the first cycle after rst deasserts.

## Timing
- Grant in cycle T.
- Read beat k valid in cycle T+(k+1)·LAT. Last beat and done in cycle T+BURST·LAT.
- Write: mem_wr and done in cycle T+LAT; the memory is updated at the end of that cycle.
- Back in IDLE the cycle after done; the next grant comes no earlier than done+1. A back-to-back read pair therefore has a 1-cycle gap.
- busy = 1 from T+1 through the done cycle.

## Configuration
- ARB_RR_EN:
  - Defined: round-robin. On a simultaneous i_req and d_req, grant the side not granted most recently. The last-grant register resets to I, so D wins the first tie. A lone request is always granted.
  - Undefined: fixed priority. D always wins a tie, and the I side can starve under continuous D traffic.

## Test plan
(LAT=4, BURST=8)
- I read: i_req, i_addr=0x0013 → i_grant at T; beats at T+4, 8, …, 32 with rd_addr 0x0010…0x001E and rd_dst=0; done at T+32; 8 beats total.
- D write then D read: write d_addr=0x0041, d_wdata=0xBEEF → mem_wr high only at T+4, mem_addr=0x0040, done at T+4. Then a D read of 0x0040 → first beat rd_data=0xBEEF.
- Simultaneous i_req and d_req, repeated 3 times:
  - Without the macro: 3 consecutive D grants.
  - With the macro: grant order D, I, D.
- A request while busy: i_req raised at T+5 during a D burst → no grant until the cycle after done; grant then follows.
- Reset mid-burst: rst at T+10 → rd_valid, done and busy are 0 the next cycle; a pending write never asserts mem_wr. Following a new request, a full 8-beat burst completes.
- Idle: no requests for 20 cycles → mem_enable=0, busy=0, all outputs 0.
